// File: rtl/bus_frame_receiver.sv
// Receive node for the shared 1-bit serial bus.
// Tracks every 78-bit frame (start|src|dst|data|crc|stop, MSB-first), checks the
// destination address and CRC-4, and delivers good frames addressed to this node
// (or broadcast) through a one-entry valid/ready output buffer.
module bus_frame_receiver #(
    parameter int                 DATA_W    = 64,
    parameter int                 ADDR_W    = 4,
    parameter int                 CRC_W     = 4,
    parameter logic [ADDR_W-1:0]  NODE_ADDR = 4'd1,
    parameter logic [CRC_W-1:0]   CRC_POLY  = 4'b0011
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_in,
    input  logic              rx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic [ADDR_W-1:0] rx_src,
    output logic              crc_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SRC  = 3'd1,
        DST  = 3'd2,
        DATA = 3'd3,
        CRC  = 3'd4,
        STOP = 3'd5
    } state_t;

    // Last bit index of each field for the 7-bit field counter
    localparam logic [6:0] SRC_LAST  = 7'(ADDR_W - 1);
    localparam logic [6:0] DST_LAST  = 7'(ADDR_W - 1);
    localparam logic [6:0] DATA_LAST = 7'(DATA_W - 1);
    localparam logic [6:0] CRC_LAST  = 7'(CRC_W - 1);
    localparam logic [ADDR_W-1:0] BCAST_ADDR = '1;

    state_t             state_reg, state_next;
    logic [6:0]         cnt_reg, cnt_next;
    logic [ADDR_W-1:0]  src_reg;
    logic [ADDR_W-1:0]  dst_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [CRC_W-1:0]   rx_crc_reg;
    logic [CRC_W-1:0]   crc_reg;
    logic [CRC_W-1:0]   crc_step;
    logic               crc_fb;

    logic               rx_valid_reg;
    logic [DATA_W-1:0]  rx_data_reg;
    logic [ADDR_W-1:0]  rx_src_reg;
    logic               crc_err_reg;
    logic               frame_err_reg;
    logic               overrun_reg;

    logic               stop_cycle;
    logic               addr_match;
    logic               crc_ok;
    logic               frame_good;
    logic               pop;

    // FSM state and field-bit counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: each field advances when its last bit has been sampled
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (bus_in) begin
                    state_next = SRC;
                end
            end
            SRC: begin
                if (cnt_reg == SRC_LAST) begin
                    state_next = DST;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            DST: begin
                if (cnt_reg == DST_LAST) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            DATA: begin
                if (cnt_reg == DATA_LAST) begin
                    state_next = CRC;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            CRC: begin
                if (cnt_reg == CRC_LAST) begin
                    state_next = STOP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            STOP: begin
                // The stop-cycle bit is never reused as a start bit
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // One serial CRC step over the bit currently on the bus
    always_comb begin
        crc_fb   = crc_reg[CRC_W-1] ^ bus_in;
        crc_step = {crc_reg[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
    end

    // Field shift registers and running CRC (CRC covers src, dst and data only)
    always_ff @(posedge clock) begin
        if (reset) begin
            src_reg    <= '0;
            dst_reg    <= '0;
            data_reg   <= '0;
            rx_crc_reg <= '0;
            crc_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    crc_reg <= '0;
                end
                SRC: begin
                    src_reg <= {src_reg[ADDR_W-2:0], bus_in};
                    crc_reg <= crc_step;
                end
                DST: begin
                    dst_reg <= {dst_reg[ADDR_W-2:0], bus_in};
                    crc_reg <= crc_step;
                end
                DATA: begin
                    data_reg <= {data_reg[DATA_W-2:0], bus_in};
                    crc_reg  <= crc_step;
                end
                CRC: begin
                    rx_crc_reg <= {rx_crc_reg[CRC_W-2:0], bus_in};
                end
                default: begin
                end
            endcase
        end
    end

    // Frame completion decode; all fields are complete once the FSM is in STOP
    assign stop_cycle = (state_reg == STOP);
    assign addr_match = (dst_reg == NODE_ADDR) || (dst_reg == BCAST_ADDR);
    assign crc_ok     = (crc_reg == rx_crc_reg);
    assign frame_good = stop_cycle && !bus_in && addr_match && crc_ok;
    assign pop        = rx_valid_reg && rx_ready;

    // Output buffer and one-cycle status pulses; frames for other nodes stay silent
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_valid_reg  <= 1'b0;
            rx_data_reg   <= '0;
            rx_src_reg    <= '0;
            crc_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            crc_err_reg   <= stop_cycle && !bus_in && addr_match && !crc_ok;
            frame_err_reg <= stop_cycle && bus_in && addr_match;
            overrun_reg   <= frame_good && rx_valid_reg && !pop;
            if (frame_good && (!rx_valid_reg || pop)) begin
                rx_valid_reg <= 1'b1;
                rx_data_reg  <= data_reg;
                rx_src_reg   <= src_reg;
            end else if (pop) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_valid  = rx_valid_reg;
    assign rx_data   = rx_data_reg;
    assign rx_src    = rx_src_reg;
    assign crc_err   = crc_err_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != IDLE);

endmodule
